// File: rtl/sp_pkg.sv
// Shared types and default geometry for the down-growing stack pointer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// sp_op_t is the decoded per-cycle operation. The top decodes it from the
// raw enables, and it is handy when probing the design during debug.
package sp_pkg;

  typedef enum logic [1:0] {
    SP_NOP  = 2'd0,
    SP_PUSH = 2'd1,
    SP_POP  = 2'd2,
    SP_LOAD = 2'd3
  } sp_op_t;

  localparam int          SP_WIDTH      = 12;
  localparam logic [11:0] SP_STACK_TOP  = 12'hFFF;
  localparam logic [11:0] SP_STACK_BASE = 12'hF00;

endpackage

// File: rtl/sp_depth_tracker.sv
// High-water mark of stack depth: peak <= max(peak, depth) every edge.
// Latency: 1 cycle (registered peak).
// Backpressure: none; samples depth every cycle.
//
// Ports:
//   clock  in   1      rising-edge clock
//   rst    in   1      synchronous active-high reset, clears peak
//   depth  in   WIDTH  depth the pointer will hold after this edge
//   peak   out  WIDTH  largest depth seen since reset
//
// This module is only compiled when SP_WATERMARK_EN is defined, so the
// default build carries no unused module.
`ifdef SP_WATERMARK_EN
module sp_depth_tracker #(
  parameter int WIDTH = 12
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] depth,
  output logic [WIDTH-1:0] peak
);

  always_ff @(posedge clock) begin
    if (rst) begin
      peak <= '0;
    end else if (depth > peak) begin
      peak <= depth;
    end
  end

endmodule
`endif

// File: rtl/stack_pointer_register.sv
// Down-growing stack pointer: push decrements, pop increments, load replaces; sticky error flags.
// Latency: 1 cycle; every update is visible on dataOut the cycle after the enable.
// Backpressure: none; illegal requests are dropped and recorded in overflow/underflow.
//
// Ports:
//   clock      in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset (pointer -> STACK_TOP, flags cleared)
//   dataIn     in   WIDTH  pointer value to load
//   writeEn    in   1      load dataIn (takes priority over push/pop)
//   pushEn     in   1      reserve one slot (pointer - 1)
//   popEn      in   1      release one slot (pointer + 1)
//   clrErr     in   1      clear sticky flags (a same-cycle error event still sets its flag)
//   dataOut    out  WIDTH  registered pointer
//   full       out  1      pointer == STACK_BASE
//   empty      out  1      pointer == STACK_TOP
//   overflow   out  1      sticky: push while full, or out-of-range load
//   underflow  out  1      sticky: pop while empty
//   peakDepth  out  WIDTH  high-water depth since reset; tied to 0 unless SP_WATERMARK_EN is defined
module stack_pointer_register
  import sp_pkg::*;
#(
  parameter int             WIDTH      = SP_WIDTH,
  parameter logic [WIDTH-1:0] STACK_TOP  = WIDTH'(SP_STACK_TOP),
  parameter logic [WIDTH-1:0] STACK_BASE = WIDTH'(SP_STACK_BASE)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             writeEn,
  input  logic             pushEn,
  input  logic             popEn,
  input  logic             clrErr,
  output logic [WIDTH-1:0] dataOut,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow,
  output logic [WIDTH-1:0] peakDepth
);

  localparam logic [WIDTH-1:0] SPAN = STACK_TOP - STACK_BASE;

  sp_op_t           op;
  logic [WIDTH-1:0] sp_d;
  logic             load_ok;
  logic             ovf_evt;
  logic             unf_evt;

  assign full  = (dataOut == STACK_BASE);
  assign empty = (dataOut == STACK_TOP);

  // Offset from BASE in modular arithmetic: anything below BASE wraps to a
  // large value, so a single compare against the span covers both bounds.
  assign load_ok = ((dataIn - STACK_BASE) <= SPAN);

  // Push and pop together cancel to a no-op, even at the full/empty limits.
  always_comb begin
    op = SP_NOP;
    if (writeEn) begin
      op = SP_LOAD;
    end else if (pushEn && !popEn) begin
      op = SP_PUSH;
    end else if (popEn && !pushEn) begin
      op = SP_POP;
    end
  end

  always_comb begin
    sp_d    = dataOut;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    case (op)
      SP_LOAD: begin
        if (load_ok) sp_d = dataIn;
        else         ovf_evt = 1'b1;
      end
      SP_PUSH: begin
        if (!full) sp_d = dataOut - WIDTH'(1);
        else       ovf_evt = 1'b1;
      end
      SP_POP: begin
        if (!empty) sp_d = dataOut + WIDTH'(1);
        else        unf_evt = 1'b1;
      end
      default: ;
    endcase
  end

  // A same-cycle error event beats clrErr.
  always_ff @(posedge clock) begin
    if (rst) begin
      dataOut   <= STACK_TOP;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      dataOut   <= sp_d;
      overflow  <= (overflow  & ~clrErr) | ovf_evt;
      underflow <= (underflow & ~clrErr) | unf_evt;
    end
  end

`ifdef SP_WATERMARK_EN
  logic [WIDTH-1:0] depth_next;

  // Track the depth the pointer is about to take so peak lines up with dataOut.
  assign depth_next = STACK_TOP - sp_d;

  sp_depth_tracker #(
    .WIDTH (WIDTH)
  ) u_depth_tracker (
    .clock (clock),
    .rst   (rst),
    .depth (depth_next),
    .peak  (peakDepth)
  );
`else
  assign peakDepth = '0;
`endif

endmodule

// File: tb/tb_stack_pointer_register.sv
// Directed bench for stack_pointer_register with hand-computed expectations.
module tb_stack_pointer_register;
  import sp_pkg::*;

  logic        clock;
  logic        rst;
  logic [11:0] dataIn;
  logic        writeEn;
  logic        pushEn;
  logic        popEn;
  logic        clrErr;
  logic [11:0] dataOut;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        underflow;
  logic [11:0] peakDepth;

  int passed = 0;
  int total  = 0;

`ifdef SP_WATERMARK_EN
  localparam logic [11:0] PEAK5 = 12'd5;
`else
  localparam logic [11:0] PEAK5 = 12'd0;
`endif

  stack_pointer_register dut (
    .clock     (clock),
    .rst       (rst),
    .dataIn    (dataIn),
    .writeEn   (writeEn),
    .pushEn    (pushEn),
    .popEn     (popEn),
    .clrErr    (clrErr),
    .dataOut   (dataOut),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow),
    .peakDepth (peakDepth)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge, then settle away from the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [11:0] sp,
                           input logic f, input logic e, input logic o, input logic u);
    chk({tag, ".dataOut"},   {4'h0, dataOut}, {4'h0, sp});
    chk({tag, ".full"},      {15'h0, full},      {15'h0, f});
    chk({tag, ".empty"},     {15'h0, empty},     {15'h0, e});
    chk({tag, ".overflow"},  {15'h0, overflow},  {15'h0, o});
    chk({tag, ".underflow"}, {15'h0, underflow}, {15'h0, u});
  endtask

  initial begin
    rst = 1'b1; dataIn = '0; writeEn = 0; pushEn = 0; popEn = 0; clrErr = 0;
    #2;

    // 1. reset state
    step();
    chk_flags("reset", 12'hFFF, 0, 1, 0, 0);
    chk("reset.peak", {4'h0, peakDepth}, 16'h0);
    rst = 1'b0;

    // 2. three pushes, three pops
    pushEn = 1;
    step(); chk("push1", {4'h0, dataOut}, 16'hFFE);
    step(); chk("push2", {4'h0, dataOut}, 16'hFFD);
    step(); chk_flags("push3", 12'hFFC, 0, 0, 0, 0);
    pushEn = 0; popEn = 1;
    step(); chk("pop1", {4'h0, dataOut}, 16'hFFD);
    step(); chk("pop2", {4'h0, dataOut}, 16'hFFE);
    step(); chk_flags("pop3", 12'hFFF, 0, 1, 0, 0);

    // 3. pop while empty, then clear
    step(); chk_flags("pop_empty", 12'hFFF, 0, 1, 0, 1);
    popEn = 0; clrErr = 1;
    step(); chk_flags("clr_unf", 12'hFFF, 0, 1, 0, 0);
    clrErr = 0;

    // 4. load BASE, push while full, illegal load
    writeEn = 1; dataIn = 12'hF00;
    step(); chk_flags("load_base", 12'hF00, 1, 0, 0, 0);
    writeEn = 0; pushEn = 1;
    step(); chk_flags("push_full", 12'hF00, 1, 0, 1, 0);
    pushEn = 0; clrErr = 1;
    step(); chk_flags("clr_ovf", 12'hF00, 1, 0, 0, 0);
    clrErr = 0; writeEn = 1; dataIn = 12'h123;
    step(); chk_flags("load_oor", 12'hF00, 1, 0, 1, 0);
    // clear plus a fresh error on the same edge: the event wins
    writeEn = 0; pushEn = 1; clrErr = 1;
    step(); chk_flags("clr_vs_evt", 12'hF00, 1, 0, 1, 0);
    pushEn = 0;
    step(); chk_flags("clr_only", 12'hF00, 1, 0, 0, 0);
    clrErr = 0;

    // 5. simultaneous push+pop at both limits; load beats push
    pushEn = 1; popEn = 1;
    step(); chk_flags("pp_full", 12'hF00, 1, 0, 0, 0);
    writeEn = 1; dataIn = 12'hFFF;
    step(); chk_flags("load_top", 12'hFFF, 0, 1, 0, 0);
    writeEn = 0;
    step(); chk_flags("pp_empty", 12'hFFF, 0, 1, 0, 0);
    popEn = 0; writeEn = 1; dataIn = 12'hF80;
    step(); chk_flags("load_push", 12'hF80, 0, 0, 0, 0);
    writeEn = 0;
    step(); chk("push_f80", {4'h0, dataOut}, 16'hF7F);
    pushEn = 0;

    // 6. watermark and reset mid-burst
    rst = 1;
    step(); chk("rst2.peak", {4'h0, peakDepth}, 16'h0);
    chk("rst2.dataOut", {4'h0, dataOut}, 16'hFFF);
    rst = 0; pushEn = 1;
    for (int i = 0; i < 5; i++) step();
    chk("push5", {4'h0, dataOut}, 16'hFFA);
    pushEn = 0; popEn = 1;
    for (int i = 0; i < 5; i++) step();
    chk("pop5", {4'h0, dataOut}, 16'hFFF);
    chk("peak5", {4'h0, peakDepth}, {4'h0, PEAK5});
    popEn = 0; pushEn = 1;
    step(); step(); step();
    chk("burst", {4'h0, dataOut}, 16'hFFC);
    rst = 1;
    step(); chk_flags("rst_burst", 12'hFFF, 0, 1, 0, 0);
    chk("rst_burst.peak", {4'h0, peakDepth}, 16'h0);
    rst = 0;
    step(); chk("after_rst", {4'h0, dataOut}, 16'hFFE);
    pushEn = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
